line_writer: RTL
================

LINE_WRITER -- requirements
Module: line_writer

Interface
REQ-001 Parameter MEM_DEPTH, default 255: number of usable character-memory words (addresses 0..MEM_DEPTH-1); address 8'hFF is the out-of-bounds sentinel and is never written.
REQ-002 Parameter MAX_LINES, default 256: number of pointer-table entries.
REQ-003 clk  in  1  sole clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 in_valid  in  1  character beat valid.
REQ-006 in_ready  out  1  block accepts beat; transfer occurs when in_valid & in_ready at a rising edge.
REQ-007 in_lhs  in  8  input-side ASCII char.
REQ-008 in_rhs  in  8  transformed-side ASCII char.
REQ-009 in_last  in  1  beat is final char of current line.
REQ-010 mem_we  out  1  char-memory write strobe.
REQ-011 mem_addr  out  8  char-memory write address.
REQ-012 mem_din  out  16  write data {lhs[15:8], rhs[7:0]}.
REQ-013 ptr_we  out  1  pointer-table write strobe.
REQ-014 ptr_line  out  8  pointer-table index (line number).
REQ-015 ptr_din  out  16  pointer entry {len[15:8], start[7:0]}.
REQ-016 line_count  out  8  number of committed lines.
REQ-017 full  out  1  no further beats will be accepted.
REQ-018 overflow  out  1  sticky: a line was truncated by memory exhaustion.

Function
REQ-019 FSM states IDLE, WRITE, COMMIT, FULL; all outputs are registered.
REQ-020 in_ready SHALL be 1 in IDLE and WRITE when wr_ptr < MEM_DEPTH, else 0; always 0 in COMMIT and FULL.
REQ-021 Accepted beat at edge N: during cycle N+1 mem_we=1, mem_addr=wr_ptr(old), mem_din={in_lhs,in_rhs}; wr_ptr and char_count increment by 1.
REQ-022 First beat of a line latches line_start=wr_ptr; IDLE->WRITE.
REQ-023 Beat with in_last=1: next state COMMIT; in COMMIT ptr_we=1 for exactly one cycle, ptr_line=line_count, ptr_din={char_count, line_start}.
REQ-024 COMMIT exit: line_count+1, char_count cleared; ->FULL if line_count+1 == MAX_LINES or wr_ptr >= MEM_DEPTH, else ->IDLE.
REQ-025 Beat with in_last=0 accepted at wr_ptr == MEM_DEPTH-1: line is truncated; overflow set; ->COMMIT with len = chars written; then ->FULL.
REQ-026 Line length is 1..255; char_count is 8-bit and cannot wrap given MEM_DEPTH <= 255.
REQ-027 mem_we and ptr_we are 0 in every cycle not listed above; mem_addr holds 8'hFF when mem_we=0.
REQ-028 full=1 exactly while in FULL; FULL is left only by reset.
REQ-029 Beats presented while in_ready=0 are not consumed; in_lhs/in_rhs/in_last are sampled only on a transfer.

Reset
REQ-030 rst=0 at a rising edge: state IDLE, wr_ptr=0, char_count=0, line_start=0, line_count=0, mem_we=0, ptr_we=0, mem_addr=8'hFF, mem_din=0, ptr_line=0, ptr_din=0, full=0, overflow=0, in_ready=0 in that cycle and 1 the following cycle.
REQ-031 Reset mid-line or mid-COMMIT discards the partial line; no ptr_we is issued for it.

Configuration
REQ-032 Macro LINE_WRITER_TERM_EN defined: in COMMIT, if wr_ptr < MEM_DEPTH, additionally mem_we=1, mem_addr=wr_ptr, mem_din=16'h0000 (terminator), and wr_ptr increments; terminator is not counted in len; if no slot remains, terminator is skipped.
REQ-033 Macro undefined: COMMIT issues no memory write; lines are packed contiguously.

Verification
REQ-034 Reset, then beats ('a','A'),('b','B'),('c','C' last) back-to-back -> mem writes at 0,1,2 = 16'h6141,16'h6242,16'h6343; ptr_we at line 0 with ptr_din=16'h0300; line_count=1.
REQ-035 Two lines of lengths 2 and 1, term disabled -> ptr entries 16'h0200 @0, 16'h0102 @1; with LINE_WRITER_TERM_EN -> 16'h0200 @0, 16'h0103 @1, 16'h0000 written at addr 2.
REQ-036 Single 300-beat line with in_last only on beat 300 -> 255 writes (addr 0..254), ptr_din=16'hFF00, overflow=1, full=1, in_ready=0 thereafter.
REQ-037 MAX_LINES=4, five 1-char lines -> four ptr_we at lines 0..3, full=1 after fourth COMMIT, fifth beat never accepted.
REQ-038 in_valid toggled every other cycle during a 4-char line -> exactly 4 writes at consecutive addresses, no duplicate or dropped beats.
REQ-039 rst=0 asserted after 2 beats of a 3-char line -> no ptr_we; after release, next line starts at addr 0 as line 0.

Source files
------------

// File: rtl/line_writer_if.sv
// line_writer_if: character-beat input, memory/pointer-table write ports and status of line_writer
interface line_writer_if;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_lhs;
   logic [7:0]  in_rhs;
   logic        in_last;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_din;
   logic        ptr_we;
   logic [7:0]  ptr_line;
   logic [15:0] ptr_din;
   logic [7:0]  line_count;
   logic        full;
   logic        overflow;
   modport slave (
      input  in_valid, in_lhs, in_rhs, in_last,
      output in_ready, mem_we, mem_addr, mem_din, ptr_we, ptr_line, ptr_din, line_count, full, overflow
   );
   modport master (
      output in_valid, in_lhs, in_rhs, in_last,
      input  in_ready, mem_we, mem_addr, mem_din, ptr_we, ptr_line, ptr_din, line_count, full, overflow
   );
endinterface

// File: rtl/line_writer.sv
// line_writer: packs character beats into a char memory and records {len,start} per line; LINE_WRITER_TERM_EN adds a 16'h0000 terminator after each line
module line_writer #(
   parameter int MEM_DEPTH = 255,
   parameter int MAX_LINES = 256
) (
   input logic         clk,
   input logic         rst,
   line_writer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WRITE, COMMIT, FULL} state_t;
   localparam logic [8:0] DEPTH = 9'(MEM_DEPTH);
   localparam logic [8:0] LINES = 9'(MAX_LINES);
   state_t      state_q, state_d;
   logic [7:0]  wr_ptr_q, wr_ptr_d, char_count_q, char_count_d;
   logic [7:0]  line_start_q, line_start_d, line_count_q, line_count_d;
   logic [7:0]  mem_addr_q, mem_addr_d, ptr_line_q, ptr_line_d;
   logic [15:0] mem_din_q, mem_din_d, ptr_din_q, ptr_din_d;
   logic        in_ready_q, in_ready_d, mem_we_q, mem_we_d, ptr_we_q, ptr_we_d;
   logic        full_q, full_d, overflow_q, overflow_d;
   logic        accept, trunc, commit, term, room_after, lines_done;
   assign accept = bus.in_valid & in_ready_q;
   assign trunc  = accept & ~bus.in_last & ({1'b0, wr_ptr_q} == DEPTH - 9'd1);
   assign commit = state_q == COMMIT;
`ifdef LINE_WRITER_TERM_EN
   assign term = commit & ({1'b0, wr_ptr_q} < DEPTH);
`else
   assign term = 1'b0;
`endif
   assign wr_ptr_d   = wr_ptr_q + 8'(accept | term);
   assign room_after = {1'b0, wr_ptr_d} < DEPTH;
   assign lines_done = {1'b0, line_count_q} + 9'd1 == LINES;
   // state and registered outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         wr_ptr_q     <= 8'd0;
         char_count_q <= 8'd0;
         line_start_q <= 8'd0;
         line_count_q <= 8'd0;
         in_ready_q   <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 8'hFF;
         mem_din_q    <= 16'h0000;
         ptr_we_q     <= 1'b0;
         ptr_line_q   <= 8'd0;
         ptr_din_q    <= 16'h0000;
         full_q       <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         char_count_q <= char_count_d;
         line_start_q <= line_start_d;
         line_count_q <= line_count_d;
         in_ready_q   <= in_ready_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_din_q    <= mem_din_d;
         ptr_we_q     <= ptr_we_d;
         ptr_line_q   <= ptr_line_d;
         ptr_din_q    <= ptr_din_d;
         full_q       <= full_d;
         overflow_q   <= overflow_d;
      end
   end
   // a final or truncating beat closes the line; COMMIT decides between more lines and FULL
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, WRITE: if (accept) state_d = (bus.in_last | trunc) ? COMMIT : WRITE;
         COMMIT:      state_d = (lines_done | ~room_after) ? FULL : IDLE;
         default:     state_d = FULL;
      endcase
   end
   // datapath and output next values; COMMIT publishes the pointer entry of the line just closed
   always_comb begin
      char_count_d = commit ? 8'd0 : char_count_q + 8'(accept);
      line_start_d = (accept && state_q == IDLE) ? wr_ptr_q : line_start_q;
      line_count_d = line_count_q + 8'(commit);
      overflow_d   = overflow_q | trunc;
      mem_we_d     = accept | term;
      mem_addr_d   = mem_we_d ? wr_ptr_q : 8'hFF;
      mem_din_d    = accept ? {bus.in_lhs, bus.in_rhs} : 16'h0000;
      ptr_we_d     = commit;
      ptr_line_d   = commit ? line_count_q : ptr_line_q;
      ptr_din_d    = commit ? {char_count_q, line_start_q} : ptr_din_q;
      full_d       = state_d == FULL;
      in_ready_d   = (state_d == IDLE || state_d == WRITE) && room_after;
   end
   assign bus.in_ready   = in_ready_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_din    = mem_din_q;
   assign bus.ptr_we     = ptr_we_q;
   assign bus.ptr_line   = ptr_line_q;
   assign bus.ptr_din    = ptr_din_q;
   assign bus.line_count = line_count_q;
   assign bus.full       = full_q;
   assign bus.overflow   = overflow_q;
endmodule
